// File: rtl/s_araw_cmd_arbiter.sv
// s_araw_cmd_arbiter: merges the AXI AR and AW address channels into one shared command FIFO.
//   AR*/AW*      : slave-side address channels; ready is granted combinationally from valid.
//   mem_w*       : write port of the external FIFO memory, entry = {is_write, payload}.
//   mem_r*       : read index out, combinational read data in.
//   cmd_*        : head entry handed to the single downstream command consumer.
//   count        : occupancy, 0..2^ADDRW.
module s_araw_cmd_arbiter #(
    parameter int ADDRW = 4,
    parameter int CMDW  = 48
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [CMDW-1:0]   ARCMD,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [CMDW-1:0]   AWCMD,
    output logic [CMDW:0]     mem_wdata,
    output logic [ADDRW-1:0]  mem_waddr,
    output logic              mem_wpush,
    output logic              mem_wfull,
    output logic [ADDRW-1:0]  mem_raddr,
    input  logic [CMDW:0]     mem_rdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_is_write,
    output logic [CMDW-1:0]   cmd_payload,
    output logic [ADDRW:0]    count
);
    localparam logic [ADDRW:0] ptr_one = 1;
    logic [ADDRW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic last_grant_q, last_grant_d;
    logic full, empty, grant_ar, grant_aw, pop;
    always_comb begin
        full         = (wptr_q[ADDRW] != rptr_q[ADDRW]) && (wptr_q[ADDRW-1:0] == rptr_q[ADDRW-1:0]);
        empty        = wptr_q == rptr_q;
        // last_grant_q = 1 means AW won last, so AR has priority on contention
        grant_ar     = ARESETn && !full && ARVALID && (!AWVALID || last_grant_q);
        grant_aw     = ARESETn && !full && AWVALID && !grant_ar;
        pop          = !empty && cmd_ready;
        wptr_d       = mem_wpush ? wptr_q + ptr_one : wptr_q;
        rptr_d       = pop ? rptr_q + ptr_one : rptr_q;
        last_grant_d = grant_aw ? 1'b1 : grant_ar ? 1'b0 : last_grant_q;
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            last_grant_q <= last_grant_d;
        end
    end
    assign ARREADY   = grant_ar;
    assign AWREADY   = grant_aw;
    assign mem_wpush = grant_ar | grant_aw;
    assign mem_wdata = grant_aw ? {1'b1, AWCMD} : {1'b0, ARCMD};
    assign mem_waddr = wptr_q[ADDRW-1:0];
    assign mem_raddr = rptr_q[ADDRW-1:0];
    assign mem_wfull = full;
    assign cmd_valid = !empty;
    assign {cmd_is_write, cmd_payload} = mem_rdata;
    assign count     = wptr_q - rptr_q;
endmodule

// File: tb/tb_s_araw_cmd_arbiter.sv
// tb_s_araw_cmd_arbiter: randomized bench against a queue-based model of the arbiter and FIFO.
module tb_s_araw_cmd_arbiter;
    localparam int ADDRW = 4;
    localparam int CMDW  = 48;
    localparam int DEPTH = 1 << ADDRW;
    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              ARVALID = 1'b0, AWVALID = 1'b0, cmd_ready = 1'b0;
    logic [CMDW-1:0]   ARCMD = '0, AWCMD = '0;
    logic              ARREADY, AWREADY, mem_wpush, mem_wfull, cmd_valid, cmd_is_write;
    logic [CMDW:0]     mem_wdata, mem_rdata;
    logic [ADDRW-1:0]  mem_waddr, mem_raddr;
    logic [CMDW-1:0]   cmd_payload;
    logic [ADDRW:0]    count;
    logic [CMDW:0]     mem [DEPTH];
    logic [CMDW:0]     q [$];
    bit                last_aw = 1'b1;
    bit                known = 1'b0;
    int                n_chk = 0, n_pass = 0, wraps = 0;
    s_araw_cmd_arbiter #(.ADDRW(ADDRW), .CMDW(CMDW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARCMD(ARCMD),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWCMD(AWCMD),
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wpush(mem_wpush), .mem_wfull(mem_wfull),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
        .cmd_payload(cmd_payload), .count(count)
    );
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) begin
        if (mem_wpush) mem[mem_waddr] <= mem_wdata;
        if (mem_wpush && mem_waddr == ADDRW'(DEPTH - 1)) wraps <= wraps + 1;
    end
    assign mem_rdata = mem[mem_raddr];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    endtask
    // One clock cycle: drive inputs, check combinational outputs against the model, then advance the model.
    task automatic step(input bit rstn, input bit arv, input bit awv, input logic [CMDW-1:0] arc,
                        input logic [CMDW-1:0] awc, input bit rdy);
        bit is_full, ga, gw;
        ARESETn = rstn; ARVALID = arv; AWVALID = awv; ARCMD = arc; AWCMD = awc; cmd_ready = rdy;
        #1;
        is_full = q.size() == DEPTH;
        ga = 0; gw = 0;
        if (rstn && !is_full) begin
            if (arv && awv) begin
                if (last_aw) ga = 1; else gw = 1;
            end else begin
                ga = arv; gw = awv;
            end
        end
        chk("arready", ARREADY, ga);
        chk("awready", AWREADY, gw);
        chk("wpush", mem_wpush, ga | gw);
        if (ga) chk("wdata_ar", mem_wdata, {1'b0, arc});
        if (gw) chk("wdata_aw", mem_wdata, {1'b1, awc});
        if (known) begin
            chk("wfull", mem_wfull, is_full);
            chk("count", count, q.size());
            chk("cmd_valid", cmd_valid, q.size() != 0);
            chk("cnt_le16", count <= DEPTH, 1);
            if (q.size() != 0) chk("head", {cmd_is_write, cmd_payload}, q[0]);
        end
        @(posedge ACLK);
        if (!rstn) begin
            q.delete();
            last_aw = 1'b1;
            known = 1'b1;
        end else begin
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (ga) begin q.push_back({1'b0, arc}); last_aw = 1'b0; end
            if (gw) begin q.push_back({1'b1, awc}); last_aw = 1'b1; end
        end
        #1;
    endtask
    function automatic logic [CMDW-1:0] rnd();
        return {$urandom_range(0, 65535), $urandom()};
    endfunction
    initial begin
        int w0;
        @(posedge ACLK); #1;
        for (int i = 0; i < 3; i++) step(0, 1, 1, rnd(), rnd(), 0);
        // Contention to full with no pops, then two stalled cycles at full.
        for (int i = 0; i < DEPTH + 2; i++) step(1, 1, 1, rnd(), rnd(), 0);
        chk("full_count", count, DEPTH);
        // Pop at full while AW waits: blocked this cycle, accepted the next.
        step(1, 0, 1, '0, rnd(), 1);
        step(1, 0, 1, '0, rnd(), 0);
        chk("refill_count", count, DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, '0, '0, 1);
        // Single AR then pop.
        step(1, 1, 0, 48'h0000_1234_5678, '0, 0);
        step(1, 0, 0, '0, '0, 0);
        chk("single_head", {cmd_is_write, cmd_payload}, {1'b0, 48'h0000_1234_5678});
        step(1, 0, 0, '0, '0, 1);
        chk("single_drained", count, 0);
        // Random traffic with a continuously ready consumer.
        w0 = wraps;
        for (int i = 0; i < 100; i++)
            step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rnd(), rnd(), 1'b1);
        chk("wraps_ge3", (wraps - w0) >= 3, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, 1);
        // Mixed random traffic with a bursty consumer to exercise fill and drain.
        for (int i = 0; i < 200; i++)
            step(1, $urandom_range(0, 1), $urandom_range(0, 1), rnd(), rnd(), $urandom_range(0, 3) == 0);
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, '0, '0, 1);
        // Reset with five entries queued.
        for (int i = 0; i < 5; i++) step(1, 1, 0, rnd(), '0, 0);
        chk("pre_reset_count", count, 5);
        step(0, 1, 1, rnd(), rnd(), 0);
        chk("post_reset_count", count, 0);
        chk("post_reset_valid", cmd_valid, 0);
        step(1, 1, 0, 48'hABCD_0000_0042, '0, 0);
        step(1, 0, 0, '0, '0, 1);
        step(1, 0, 0, '0, '0, 0);
        chk("post_reset_drained", count, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
